// File: rtl/sdram_multibank_core.sv
// rtl/sdram_multibank_core.sv - multi-bank DRAM array model with per-bank row buffers and ACT/RD/WR/PRE/PREA timing
module sdram_multibank_core #(
  parameter int NUM_BANKS = 4,
  parameter int ROW_AW    = 8,
  parameter int COL_AW    = 6,
  parameter int DW        = 32,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_RAS     = 4,
  parameter int CL        = 2,
  localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  input  logic [BW-1:0]        bank,
  input  logic [ROW_AW-1:0]    row,
  input  logic [COL_AW-1:0]    col,
  input  logic [DW-1:0]        wdata,
  output logic [DW-1:0]        rdata,
  output logic                 rdata_valid,
  output logic                 cmd_err,
  output logic [NUM_BANKS-1:0] bank_open
);

  localparam int ROWS = 1 << ROW_AW;
  localparam int COLS = 1 << COL_AW;
  localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam int RW   = $clog2(T_RAS + 1);

  typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bstate_t;

  bstate_t           st       [NUM_BANKS];
  logic [TW-1:0]     tmr      [NUM_BANKS];
  logic [RW-1:0]     ras      [NUM_BANKS];
  logic [ROW_AW-1:0] open_row [NUM_BANKS];
  logic [DW-1:0]     rowbuf   [NUM_BANKS][COLS];
  logic [DW-1:0]     mem      [NUM_BANKS][ROWS][COLS];
  logic [DW-1:0]     pipe_d   [CL];
  logic [CL-1:0]     pipe_v;

  logic                 act_go, rd_go, wr_go, err, prea_bad, pre_bad;
  logic [NUM_BANKS-1:0] ras_met, wb;

  // Command legality is decided against the current bank states, before this edge updates them.
  always_comb begin
    ras_met  = '0;
    wb       = '0;
    prea_bad = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ras_met[b] = (ras[b] >= RW'(T_RAS));
      if (st[b] != B_IDLE && !(st[b] == B_ACTIVE && ras_met[b]))
        prea_bad = 1'b1;
    end
    act_go  = cmd_valid && cmd == 3'b001 && st[bank] == B_IDLE;
    rd_go   = cmd_valid && cmd == 3'b010 && st[bank] == B_ACTIVE;
    wr_go   = cmd_valid && cmd == 3'b011 && st[bank] == B_ACTIVE;
    pre_bad = cmd_valid && cmd == 3'b100 && st[bank] != B_IDLE &&
              !(st[bank] == B_ACTIVE && ras_met[bank]);
    for (int b = 0; b < NUM_BANKS; b++) begin
      wb[b] = (cmd_valid && cmd == 3'b100 && bank == BW'(b) && st[b] == B_ACTIVE && ras_met[b]) ||
              (cmd_valid && cmd == 3'b101 && !prea_bad && st[b] == B_ACTIVE);
    end
    err = cmd_valid && ((cmd[2] && cmd[1]) ||
                        (cmd == 3'b001 && !act_go) ||
                        (cmd == 3'b010 && !rd_go) ||
                        (cmd == 3'b011 && !wr_go) ||
                        pre_bad ||
                        (cmd == 3'b101 && prea_bad));
  end

  always_comb begin
    bank_open = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_open[b] = (st[b] == B_ACTIVE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st[b]  <= B_IDLE;
        tmr[b] <= '0;
        ras[b] <= '0;
      end
      for (int i = 0; i < CL; i++) pipe_d[i] <= '0;
      pipe_v      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        case (st[b])
          B_IDLE:
            if (act_go && bank == BW'(b)) begin
              st[b]  <= B_ACTIVATING;
              tmr[b] <= TW'(T_RCD - 1);
              ras[b] <= RW'(1);
            end
          B_ACTIVATING:
            if (tmr[b] == '0) st[b] <= B_ACTIVE;
            else              tmr[b] <= tmr[b] - 1'b1;
          B_ACTIVE:
            if (wb[b]) begin
              st[b]  <= B_PRECHARGING;
              tmr[b] <= TW'(T_RP - 1);
            end
          default:
            if (tmr[b] == '0) st[b] <= B_IDLE;
            else              tmr[b] <= tmr[b] - 1'b1;
        endcase
        if (st[b] != B_IDLE && !ras_met[b]) ras[b] <= ras[b] + 1'b1;
      end
      // Read data is captured at accept, so a later precharge cannot disturb it.
      pipe_v[0] <= rd_go;
      if (rd_go) pipe_d[0] <= rowbuf[bank][col];
      for (int i = 1; i < CL; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      rdata_valid <= pipe_v[CL-1];
      if (pipe_v[CL-1]) rdata <= pipe_d[CL-1];
      cmd_err <= err;
    end
  end

  // Array and row buffers are storage only; reset leaves their contents alone.
  always_ff @(posedge clk) begin
    if (act_go) begin
      open_row[bank] <= row;
      for (int c = 0; c < COLS; c++) rowbuf[bank][COL_AW'(c)] <= mem[bank][row][COL_AW'(c)];
    end
    if (wr_go) rowbuf[bank][col] <= wdata;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wb[b]) begin
        for (int c = 0; c < COLS; c++)
          mem[BW'(b)][open_row[BW'(b)]][COL_AW'(c)] <= rowbuf[BW'(b)][COL_AW'(c)];
      end
    end
  end

endmodule

// File: tb/tb_sdram_multibank_core.sv
// tb/tb_sdram_multibank_core.sv - scoreboard bench for sdram_multibank_core
module tb_sdram_multibank_core;
  localparam int T_RCD = 2;
  localparam int T_RP  = 2;
  localparam int T_RAS = 4;
  localparam int CL    = 2;

  localparam logic [2:0] NOP = 3'b000, ACT = 3'b001, RD = 3'b010, WR = 3'b011,
                         PRE = 3'b100, PREA = 3'b101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  bank;
  logic [7:0]  row;
  logic [5:0]  col;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        cmd_err;
  logic [3:0]  bank_open;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  sdram_multibank_core #(
    .NUM_BANKS(4), .ROW_AW(8), .COL_AW(6), .DW(32),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .CL(CL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd), .bank(bank),
    .row(row), .col(col), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .cmd_err(cmd_err), .bank_open(bank_open)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Read scoreboard: each pushed read must appear exactly on its due cycle, in order.
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: rdata_valid with rdata=%h, no read outstanding", rdata);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.data || cyc != e.due) begin
          fails++;
          $display("FAIL rd_data: got %h at cycle %0d, want %h at cycle %0d", rdata, cyc, e.data, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      tests++;
      fails++;
      e = sb.pop_front();
      $display("FAIL rd_missing: no rdata_valid at cycle %0d, want %h", e.due, e.data);
    end
  end

  // Drives one command at a negedge; returns at the next negedge, after the accept edge.
  task automatic issue(input logic [2:0] c, input int b, input int r, input int cl, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd       = c;
    bank      = b[1:0];
    row       = r[7:0];
    col       = cl[5:0];
    wdata     = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = NOP;
  endtask

  task automatic rd(input int b, input int cl, input logic [31:0] exp_data);
    exp_t x;
    x.data = exp_data;
    x.due  = cyc + 1 + CL;
    sb.push_back(x);
    issue(RD, b, 0, cl, 32'h0);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    cmd       = NOP;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({rdata_valid, cmd_err, bank_open} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctl: valid/err/open=%b, want 000000", {rdata_valid, cmd_err, bank_open});
    end
    tests++;
    if (rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h, want 00000000", rdata);
    end
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_rw;
    issue(ACT, 0, 2, 0, 32'h0);
    idle(T_RCD - 1);
    tests++;
    if (bank_open[0] !== 1'b0) begin
      fails++;
      $display("FAIL trcd_early: bank_open[0]=%b, want 0", bank_open[0]);
    end
    idle(1);
    tests++;
    if (bank_open[0] !== 1'b1) begin
      fails++;
      $display("FAIL trcd_open: bank_open[0]=%b, want 1", bank_open[0]);
    end
    issue(WR, 0, 0, 5, 32'hF0F0F0F0);
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL wr_accept: cmd_err=%b, want 0", cmd_err);
    end
    rd(0, 5, 32'hF0F0F0F0);
    idle(CL + 2);
    tests++;
    if (rdata !== 32'hF0F0F0F0 || rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL rdata_hold: rdata=%h valid=%b, want F0F0F0F0 0", rdata, rdata_valid);
    end
  endtask

  task automatic test_writeback;
    issue(ACT, 1, 7, 0, 32'h0);
    idle(T_RCD);
    issue(WR, 1, 0, 0, 32'hA5A5A5A5);
    issue(PRE, 1, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b0 || bank_open[1] !== 1'b0) begin
      fails++;
      $display("FAIL pre_accept: cmd_err=%b bank_open[1]=%b, want 0 0", cmd_err, bank_open[1]);
    end
    idle(T_RP);
    issue(ACT, 1, 7, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL act_after_trp: cmd_err=%b, want 0", cmd_err);
    end
    idle(T_RCD);
    rd(1, 0, 32'hA5A5A5A5);
    idle(CL + 1);
    issue(PREA, 0, 0, 0, 32'h0);
    idle(T_RP + 1);
  endtask

  task automatic test_timing_errors;
    issue(ACT, 2, 4, 0, 32'h0);
    issue(RD, 2, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL rd_trcd: cmd_err=%b, want 1", cmd_err);
    end
    issue(PRE, 2, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL pre_tras: cmd_err=%b, want 1", cmd_err);
    end
    idle(1);
    tests++;
    if (cmd_err !== 1'b0 || bank_open[2] !== 1'b1) begin
      fails++;
      $display("FAIL err_strobe: cmd_err=%b bank_open[2]=%b, want 0 1", cmd_err, bank_open[2]);
    end
    issue(3'b111, 0, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL illegal_111: cmd_err=%b, want 1", cmd_err);
    end
    issue(NOP, 0, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL nop: cmd_err=%b, want 0", cmd_err);
    end
    issue(PRE, 3, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL pre_idle: cmd_err=%b, want 0", cmd_err);
    end
    issue(ACT, 2, 5, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL act_active: cmd_err=%b, want 1", cmd_err);
    end
    issue(WR, 3, 0, 0, 32'h1);
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL wr_idle: cmd_err=%b, want 1", cmd_err);
    end
    idle(2);
    issue(PREA, 0, 0, 0, 32'h0);
    issue(PRE, 2, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL pre_precharging: cmd_err=%b, want 1", cmd_err);
    end
    idle(T_RP + 1);
    tests++;
    if (bank_open !== 4'b0000) begin
      fails++;
      $display("FAIL prea_clear: bank_open=%b, want 0000", bank_open);
    end
  endtask

  task automatic test_back_to_back;
    issue(ACT, 0, 1, 0, 32'h0);
    issue(ACT, 3, 1, 0, 32'h0);
    idle(T_RCD);
    issue(WR, 0, 0, 3, 32'h11112222);
    issue(WR, 3, 0, 3, 32'h33334444);
    rd(0, 3, 32'h11112222);
    rd(3, 3, 32'h33334444);
    idle(CL + 2);
    tests++;
    if (bank_open !== 4'b1001) begin
      fails++;
      $display("FAIL iso_open: bank_open=%b, want 1001", bank_open);
    end
    issue(PREA, 0, 0, 0, 32'h0);
    idle(T_RP + 1);
  endtask

  task automatic test_prea;
    issue(ACT, 0, 9, 0, 32'h0);
    idle(T_RCD);
    issue(WR, 0, 0, 1, 32'h5A5A0F0F);
    idle(2);
    issue(ACT, 2, 0, 0, 32'h0);
    issue(PREA, 0, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b1 || bank_open !== 4'b0001) begin
      fails++;
      $display("FAIL prea_reject: cmd_err=%b bank_open=%b, want 1 0001", cmd_err, bank_open);
    end
    idle(2);
    issue(PREA, 0, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b0 || bank_open !== 4'b0000) begin
      fails++;
      $display("FAIL prea_retry: cmd_err=%b bank_open=%b, want 0 0000", cmd_err, bank_open);
    end
    idle(T_RP);
    issue(ACT, 0, 9, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL act_after_prea: cmd_err=%b, want 0", cmd_err);
    end
    idle(T_RCD);
    rd(0, 1, 32'h5A5A0F0F);
    idle(CL + 2);
  endtask

  task automatic test_reset_mid;
    issue(PREA, 0, 0, 0, 32'h0);
    idle(T_RP + 1);
    issue(ACT, 1, 3, 0, 32'h0);
    idle(T_RCD);
    rd(1, 0, 32'h0);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    tests++;
    if (bank_open !== 4'b0 || rdata_valid !== 1'b0 || rdata !== 32'h0 || cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: open=%b valid=%b rdata=%h err=%b, want 0000 0 00000000 0",
               bank_open, rdata_valid, rdata, cmd_err);
    end
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    issue(3'b110, 0, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL illegal_110: cmd_err=%b, want 1", cmd_err);
    end
    issue(RD, 1, 0, 0, 32'h0);
    tests++;
    if (cmd_err !== 1'b1) begin
      fails++;
      $display("FAIL rd_after_reset: cmd_err=%b, want 1", cmd_err);
    end
    idle(CL + 3);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd       = NOP;
    bank      = '0;
    row       = '0;
    col       = '0;
    wdata     = '0;
    test_reset();
    test_basic_rw();
    test_writeback();
    test_timing_errors();
    test_back_to_back();
    test_prea();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d reads outstanding, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
